// File: rtl/mem_line_responder.sv
// Memory side of the I-cache line fill: assembles a 4-word line from a 32-bit word array,
// one word per (LATENCY+1)-cycle beat, and answers with a level mem_req/mem_ready handshake.
module mem_line_responder #(
    parameter int MEM_WORDS  = 4096,
    parameter int LATENCY    = 2,
    parameter int CACHE_LINE = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic [31:0]           mem_addr,
    output logic [CACHE_LINE-1:0] mem_data_out,
    output logic                  mem_ready,
    output logic                  mem_err,
    input  logic                  wr_en,
    input  logic [31:0]           wr_addr,
    input  logic [31:0]           wr_data
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int WW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t                  state, state_nxt;
    logic [27:0]             base, base_nxt;
    logic [1:0]              beat, beat_nxt;
    logic [WW-1:0]           wait_cnt, wait_nxt;
    logic [95:0]             line, line_nxt;
    logic                    oob, oob_nxt;
    logic [CACHE_LINE-1:0]   data_nxt;
    logic                    ready_nxt, err_nxt;

    logic [31:0]             mem [MEM_WORDS];
    logic [29:0]             word_idx;
    logic                    word_ok, wr_ok;
    logic [31:0]             rd_word;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{mem_addr[3:0], wr_addr[1:0]};

    assign word_idx = {base, beat};
    assign word_ok  = word_idx < 30'(MEM_WORDS);
    assign rd_word  = word_ok ? mem[word_idx[AW-1:0]] : 32'h0;
    assign wr_ok    = wr_addr[31:2] < 30'(MEM_WORDS);

    // Preload port is independent of the fill FSM; the array survives reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok)
            mem[wr_addr[AW+1:2]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            base         <= '0;
            beat         <= '0;
            wait_cnt     <= '0;
            line         <= '0;
            oob          <= 1'b0;
            mem_data_out <= '0;
            mem_ready    <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            base         <= base_nxt;
            beat         <= beat_nxt;
            wait_cnt     <= wait_nxt;
            line         <= line_nxt;
            oob          <= oob_nxt;
            mem_data_out <= data_nxt;
            mem_ready    <= ready_nxt;
            mem_err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        base_nxt  = base;
        beat_nxt  = beat;
        wait_nxt  = wait_cnt;
        line_nxt  = line;
        oob_nxt   = oob;
        data_nxt  = mem_data_out;
        ready_nxt = mem_ready;
        err_nxt   = mem_err;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_nxt = FETCH;
                    base_nxt  = mem_addr[31:4];
                    beat_nxt  = 2'd0;
                    wait_nxt  = '0;
                    oob_nxt   = 1'b0;
                end
            end
            FETCH: begin
                if (!mem_req) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == WW'(LATENCY)) begin
                    wait_nxt = '0;
                    beat_nxt = beat + 2'd1;
                    oob_nxt  = oob | ~word_ok;
                    case (beat)
                        2'd0:    line_nxt[31:0]  = rd_word;
                        2'd1:    line_nxt[63:32] = rd_word;
                        2'd2:    line_nxt[95:64] = rd_word;
                        default: begin
                            // Last word goes straight to the output; the line is published whole.
                            state_nxt = RESP;
                            data_nxt  = {rd_word, line};
                            ready_nxt = 1'b1;
                            err_nxt   = oob | ~word_ok;
                        end
                    endcase
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            RESP: begin
                if (!mem_req) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
